// File: rtl/output_arbiter.sv
// output_arbiter: wormhole output-port arbiter for a 5-port router, round-robin
// packet grant with tail release and forced release after MAX_FLITS flits.
module output_arbiter #(
    parameter int MAX_FLITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req_i,
    input  logic [4:0] tail_i,
    input  logic       out_ready_i,
    output logic [3:0] address_route_o,
    output logic [4:0] gnt_o,
    output logic       xfer_o,
    output logic       busy_o,
    output logic       err_o
);
    localparam int CW = $clog2(MAX_FLITS + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    pick;
    logic [3:0]    s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          last;

    // Scan downward so the requester closest to ptr (smallest offset) wins.
    always_comb begin
        pick = ptr_q;
        s = '0;
        for (int i = 4; i >= 0; i--) begin
            s = {1'b0, ptr_q} + 4'(i);
            s = s >= 4'd5 ? s - 4'd5 : s;
            if (req_i[s[2:0]]) pick = s[2:0];
        end
    end

    assign xfer_o = state_q == BUSY && req_i[owner_q] && out_ready_i;
    assign last   = cnt_q == CW'(MAX_FLITS - 1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (|req_i) begin
                state_d = BUSY;
                owner_d = pick;
                cnt_d   = '0;
            end
        end else if (xfer_o) begin
            cnt_d = cnt_q + CW'(1);
            if (tail_i[owner_q] || last) begin
                state_d = IDLE;
                cnt_d   = '0;
                ptr_d   = owner_q == 3'd4 ? 3'd0 : owner_q + 3'd1;
                err_d   = !tail_i[owner_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy_o          = state_q == BUSY;
    assign gnt_o           = busy_o ? 5'(1) << owner_q : 5'b00000;
    assign address_route_o = busy_o ? {1'b0, owner_q} : 4'b0111;
    assign err_o           = err_q;
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed spot checks plus randomized traffic compared
// every cycle against a packet-level behavioural model of the arbiter.
module tb_output_arbiter;
    localparam int MAXF = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] req = '0, tail = '0;
    logic       ready = 1'b0;
    logic [3:0] route;
    logic [4:0] gnt;
    logic       xfer, busy, err;

    int vectors = 0, miscompares = 0;
    bit chk_en = 0;

    // model: is a packet in flight, who owns it, flits sent, where the search starts
    bit m_busy = 0, m_err = 0;
    int m_owner = 0, m_cnt = 0, m_ptr = 0;

    output_arbiter #(.MAX_FLITS(MAXF)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .tail_i(tail), .out_ready_i(ready),
        .address_route_o(route), .gnt_o(gnt), .xfer_o(xfer), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic bit bitof(input logic [4:0] v, input int i);
        return ((v >> i) & 5'd1) != 5'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_err = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else begin
            m_err = 0;
            if (!m_busy) begin
                for (int k = 0; k < 5; k++)
                    if (!m_busy && bitof(req, (m_ptr + k) % 5)) begin
                        m_busy = 1;
                        m_owner = (m_ptr + k) % 5;
                        m_cnt = 0;
                    end
            end else if (bitof(req, m_owner) && ready) begin
                m_cnt++;
                if (bitof(tail, m_owner) || m_cnt == MAXF) begin
                    m_err = !bitof(tail, m_owner);
                    m_busy = 0;
                    m_cnt = 0;
                    m_ptr = (m_owner + 1) % 5;
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("m_gnt", 32'(gnt), m_busy ? 32'(1) << m_owner : 32'd0);
        chk("m_route", 32'(route), m_busy ? 32'(m_owner) : 32'd7);
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_xfer", 32'(xfer), 32'(m_busy && bitof(req, m_owner) && ready));
        chk("m_err", 32'(err), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic o);
        req = r;
        tail = t;
        ready = o;
    endtask

    task automatic do_reset();
        tick();
        drive('0, '0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        chk_en = 1;
        look();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_route", 32'(route), 7);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_xfer", 32'(xfer), 0);
        tick();
        rst_n = 1'b1;

        // single-flit packet on N
        drive(5'b00001, 5'b00001, 1'b1);
        look();
        chk("sf_idle_xfer", 32'(xfer), 0);
        tick(); look();
        chk("sf_gnt", 32'(gnt), 5'b00001);
        chk("sf_route", 32'(route), 0);
        chk("sf_xfer", 32'(xfer), 1);
        tick(); look();
        chk("sf_rel_gnt", 32'(gnt), 0);
        chk("sf_rel_route", 32'(route), 7);

        // all inputs single-flit: round robin with a bubble between grants
        do_reset();
        drive(5'b11111, 5'b11111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(); look();
            chk("rr_gnt", 32'(gnt), 32'(1) << (k % 5));
            tick(); look();
            chk("rr_bubble", 32'(busy), 0);
        end

        // E, 3 flits with a 2-cycle stall, then ptr must favour W over N
        do_reset();
        drive(5'b00100, 5'b00000, 1'b1);
        tick(); look();
        chk("e_f1", 32'(xfer), 1);
        tick(); ready = 1'b0; look();
        chk("e_st1_xfer", 32'(xfer), 0);
        chk("e_st1_route", 32'(route), 2);
        tick(); look();
        chk("e_st2_xfer", 32'(xfer), 0);
        chk("e_st2_route", 32'(route), 2);
        tick(); ready = 1'b1; look();
        chk("e_f2", 32'(xfer), 1);
        tick(); tail = 5'b00100; look();
        chk("e_f3", 32'(xfer), 1);
        tick(); drive(5'b01001, 5'b00000, 1'b1); look();
        chk("e_rel_route", 32'(route), 7);
        tick(); look();
        chk("e_next_gnt", 32'(gnt), 5'b01000);
        chk("e_next_route", 32'(route), 3);

        // L sends MAXF flits without tail: forced release and err pulse
        do_reset();
        drive(5'b10000, 5'b00000, 1'b1);
        for (int k = 0; k < MAXF; k++) begin
            tick(); look();
            chk("l_flit", 32'(xfer), 1);
        end
        tick(); drive(5'b11111, 5'b11111, 1'b1); look();
        chk("l_err", 32'(err), 1);
        chk("l_route", 32'(route), 7);
        tick(); look();
        chk("l_err_once", 32'(err), 0);
        chk("l_next_gnt", 32'(gnt), 5'b00001);

        // reset mid-packet on S
        do_reset();
        drive(5'b00010, 5'b00000, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_gnt", 32'(gnt), 0);
        chk("mr_route", 32'(route), 7);
        chk("mr_busy", 32'(busy), 0);
        drive(5'b00110, 5'b00000, 1'b1);
        look();
        rst_n = 1'b1;
        chk("mr_err", 32'(err), 0);
        tick(); look();
        chk("mr_gnt_s", 32'(gnt), 5'b00010);

        // randomized traffic, occasional mid-cycle reset pulses
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick();
            req = 5'($urandom) | 5'($urandom);
            tail = c < 2000 ? 5'($urandom & $urandom & $urandom)
                            : 5'($urandom & $urandom & $urandom & $urandom & $urandom);
            ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
